distributor14: RTL and testbench

DISTRIBUTOR14 -- requirements
Module: distributor14

---
 rtl/distributor14.sv | 102 ++++++++++
 tb/tb_distributor14.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distributor14.sv
// rtl/distributor14.sv - four-channel data distributor with manual or round-robin targeting
//
// Purpose: accepts a 4-bit word under a valid/ready handshake and writes it into
// one of four holding registers. The target channel comes from the manual select
// {iS1,iS0}, or from a round-robin pointer when iAuto is set. Each channel
// reports its state on a full flag, which its consumer clears with an ack.
//
// Ports:
//   iClk, iRst_n        clock, asynchronous active-low reset
//   iD, iValid, oReady  offered data word and its handshake
//   iS0, iS1, iAuto     manual channel select and round-robin enable
//   oZ0..oZ3            per-channel held data
//   oFull, iAck         per-channel occupancy and consumer take strobe
//   oPtr                round-robin pointer
//   oCount              number of occupied channels

module distributor14 (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [3:0] iD,
    input  logic       iValid,
    output logic       oReady,
    input  logic       iS0,
    input  logic       iS1,
    input  logic       iAuto,
    output logic [3:0] oZ0,
    output logic [3:0] oZ1,
    output logic [3:0] oZ2,
    output logic [3:0] oZ3,
    output logic [3:0] oFull,
    input  logic [3:0] iAck,
    output logic [1:0] oPtr,
    output logic [2:0] oCount
);

    logic [3:0] z_q [0:3];
    logic [3:0] z_d [0:3];
    logic [3:0] full_q, full_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] count_q, count_d;

    logic [1:0] target;
    logic       ready;
    logic       xfer;

    always_comb begin
        target = iAuto ? ptr_q : {iS1, iS0};
        // A full target frees up in the same cycle its consumer acks it.
        ready  = ~full_q[target] | iAck[target];
        xfer   = iValid & ready;

        // Acks on empty channels are harmless: clearing an already-clear bit.
        full_d = full_q & ~iAck;
        for (int i = 0; i < 4; i++) begin
            z_d[i] = z_q[i];
        end
        ptr_d = ptr_q;

        // A write wins over an ack on the same channel (pass-through).
        if (xfer) begin
            full_d[target] = 1'b1;
            z_d[target]    = iD;
            if (iAuto) begin
                ptr_d = ptr_q + 2'd1;
            end
        end

        // Count tracks the next full value so both registers update together.
        count_d = 3'd0;
        for (int i = 0; i < 4; i++) begin
            count_d = count_d + {2'b00, full_d[i]};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 4; i++) begin
                z_q[i] <= 4'b0000;
            end
            full_q  <= 4'b0000;
            ptr_q   <= 2'd0;
            count_q <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                z_q[i] <= z_d[i];
            end
            full_q  <= full_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign oReady = ready;
    assign oZ0    = z_q[0];
    assign oZ1    = z_q[1];
    assign oZ2    = z_q[2];
    assign oZ3    = z_q[3];
    assign oFull  = full_q;
    assign oPtr   = ptr_q;
    assign oCount = count_q;

endmodule

// File: tb/tb_distributor14.sv
// tb/tb_distributor14.sv - scoreboard bench for distributor14

module tb_distributor14;

    logic       iClk;
    logic       iRst_n;
    logic [3:0] iD;
    logic       iValid;
    logic       oReady;
    logic       iS0, iS1, iAuto;
    logic [3:0] oZ0, oZ1, oZ2, oZ3;
    logic [3:0] oFull;
    logic [3:0] iAck;
    logic [1:0] oPtr;
    logic [2:0] oCount;

    distributor14 dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD     (iD),
        .iValid (iValid),
        .oReady (oReady),
        .iS0    (iS0),
        .iS1    (iS1),
        .iAuto  (iAuto),
        .oZ0    (oZ0),
        .oZ1    (oZ1),
        .oZ2    (oZ2),
        .oZ3    (oZ3),
        .oFull  (oFull),
        .iAck   (iAck),
        .oPtr   (oPtr),
        .oCount (oCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Packed view: {z3,z2,z1,z0,full,ptr,count}
    typedef logic [24:0] st_t;

    st_t        exp_q [$];
    st_t        exp_s;
    int         n_vec = 0;
    int         n_err = 0;

    logic [3:0] m_z [0:3];
    logic [3:0] m_full;
    logic [1:0] m_ptr;
    logic       m_rdy;
    logic       rdy_seen;

    function automatic st_t dut_state();
        return {oZ3, oZ2, oZ1, oZ0, oFull, oPtr, oCount};
    endfunction

    function automatic st_t model_state();
        return {m_z[3], m_z[2], m_z[1], m_z[0], m_full, m_ptr, 3'($countones(m_full))};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_z[i] = 4'b0000;
        m_full = 4'b0000;
        m_ptr  = 2'd0;
        exp_q.delete();
    endtask

    // Hold reset across one edge with a live offer, then release between edges.
    task automatic do_reset();
        iRst_n = 1'b0;
        iValid = 1'b1; iD = 4'hF; iS0 = 1'b0; iS1 = 1'b0; iAuto = 1'b0; iAck = 4'h0;
        model_clear();
        #2;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iRst_n = 1'b1;
        #1;
    endtask

    // One cycle of stimulus: the model predicts oReady and the post-edge state.
    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s,
                         input logic a, input logic [3:0] ack);
        logic [1:0] t;
        logic [3:0] nf;
        iValid = v; iD = d; iS0 = s[0]; iS1 = s[1]; iAuto = a; iAck = ack;
        #1;
        rdy_seen = oReady;
        t     = a ? m_ptr : s;
        m_rdy = !m_full[t] || ack[t];
        nf    = m_full & ~ack;
        if (v && m_rdy) begin
            nf[t]  = 1'b1;
            m_z[t] = d;
            if (a) m_ptr = m_ptr + 2'd1;
        end
        m_full = nf;
        exp_q.push_back(model_state());
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        iValid = 1'b1; iD = 4'hA; iS0 = 1'b1; iS1 = 1'b0; iAuto = 1'b0; iAck = 4'h0;
        #2;
        n_vec++;
        if (dut_state() !== 25'd0) begin
            n_err++; $display("FAIL reset_state got %h exp %h", dut_state(), 25'd0);
        end
        n_vec++;
        if (oReady !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %b exp 1", oReady);
        end
        @(posedge iClk);
        #1;
        n_vec++;
        if (dut_state() !== 25'd0) begin
            n_err++; $display("FAIL reset_no_xfer got %h exp %h", dut_state(), 25'd0);
        end
        do_reset();
    endtask

    task automatic test_manual_sweep();
        logic [3:0] pat;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pat = 4'b0001 << i;
            drive(1'b1, pat, 2'(i), 1'b0, 4'h0);
            n_vec++;
            if (rdy_seen !== 1'b1) begin
                n_err++; $display("FAIL sweep_ready ch%0d got %b exp 1", i, rdy_seen);
            end
            exp_s = exp_q.pop_front();
            n_vec++;
            if (dut_state() !== exp_s) begin
                n_err++; $display("FAIL sweep_state ch%0d got %h exp %h", i, dut_state(), exp_s);
            end
        end
        n_vec++;
        if ({oZ3, oZ2, oZ1, oZ0, oFull, oCount} !== {16'h8421, 4'b1111, 3'd4}) begin
            n_err++; $display("FAIL sweep_final got %h exp %h",
                              {oZ3, oZ2, oZ1, oZ0, oFull, oCount}, {16'h8421, 4'b1111, 3'd4});
        end
        // All full, no ack: blocked in both modes and nothing moves.
        for (int a = 0; a < 2; a++) begin
            drive(1'b1, 4'h7, 2'd1, 1'(a), 4'h0);
            n_vec++;
            if (rdy_seen !== 1'b0) begin
                n_err++; $display("FAIL allfull_ready auto=%0d got %b exp 0", a, rdy_seen);
            end
            exp_s = exp_q.pop_front();
            n_vec++;
            if (dut_state() !== exp_s) begin
                n_err++; $display("FAIL allfull_state auto=%0d got %h exp %h", a, dut_state(), exp_s);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 4'h7, 2'd2, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        drive(1'b1, 4'hF, 2'd2, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (rdy_seen !== 1'b0) begin
            n_err++; $display("FAIL bp_ready_blocked got %b exp 0", rdy_seen);
        end
        n_vec++;
        if (oZ2 !== 4'h7 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL bp_hold got %h exp %h", dut_state(), exp_s);
        end
        drive(1'b1, 4'hF, 2'd2, 1'b0, 4'b0100);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (rdy_seen !== 1'b1) begin
            n_err++; $display("FAIL bp_ready_ack got %b exp 1", rdy_seen);
        end
        n_vec++;
        if (oZ2 !== 4'hF || oFull[2] !== 1'b1 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL bp_passthru got %h exp %h", dut_state(), exp_s);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ptr_exp [0:5];
        ptr_exp[0] = 2'd0; ptr_exp[1] = 2'd1; ptr_exp[2] = 2'd2;
        ptr_exp[3] = 2'd3; ptr_exp[4] = 2'd0; ptr_exp[5] = 2'd1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (oPtr !== ptr_exp[i]) begin
                n_err++; $display("FAIL rr_ptr step%0d got %0d exp %0d", i, oPtr, ptr_exp[i]);
            end
            drive(1'b1, 4'(i + 1), 2'd3, 1'b1, 4'hF);
            exp_s = exp_q.pop_front();
            n_vec++;
            if (dut_state() !== exp_s) begin
                n_err++; $display("FAIL rr_state step%0d got %h exp %h", i, dut_state(), exp_s);
            end
        end
        n_vec++;
        if ({oPtr, oZ3, oZ2, oZ1, oZ0} !== {ptr_exp[5], 16'h4325}) begin
            n_err++; $display("FAIL rr_final got %h exp %h", {oPtr, oZ3, oZ2, oZ1, oZ0},
                              {ptr_exp[5], 16'h4325});
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        drive(1'b1, 4'h1, 2'd0, 1'b1, 4'hF);
        exp_s = exp_q.pop_front();
        drive(1'b1, 4'h2, 2'd0, 1'b1, 4'hF);
        exp_s = exp_q.pop_front();
        drive(1'b1, 4'h9, 2'd0, 1'b0, 4'hF);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (oPtr !== 2'd2 || oZ0 !== 4'h9 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL mode_manual got %h exp %h", dut_state(), exp_s);
        end
        drive(1'b1, 4'hC, 2'd0, 1'b1, 4'h0);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (oZ2 !== 4'hC || oPtr !== 2'd3 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL mode_auto got %h exp %h", dut_state(), exp_s);
        end
    endtask

    task automatic test_spurious_ack();
        do_reset();
        drive(1'b0, 4'h5, 2'd1, 1'b0, 4'hF);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (oFull !== 4'b0000 || oCount !== 3'd0 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL spurious_ack got %h exp %h", dut_state(), exp_s);
        end
    endtask

    task automatic test_random();
        logic [3:0] ack;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            ack = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 1'($urandom),
                  ack);
            n_vec++;
            if (rdy_seen !== m_rdy) begin
                n_err++; $display("FAIL rand_ready cyc%0d got %b exp %b", i, rdy_seen, m_rdy);
            end
            exp_s = exp_q.pop_front();
            n_vec++;
            if (dut_state() !== exp_s) begin
                n_err++; $display("FAIL rand_state cyc%0d got %h exp %h", i, dut_state(), exp_s);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 4'h3, 2'd0, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        drive(1'b1, 4'h6, 2'd1, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        drive(1'b1, 4'hE, 2'd3, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (oFull !== 4'b1011 || dut_state() !== exp_s) begin
            n_err++; $display("FAIL arst_setup got %h exp %h", dut_state(), exp_s);
        end
        iValid = 1'b1; iS0 = 1'b0; iS1 = 1'b1;
        iRst_n = 1'b0;
        #1;
        n_vec++;
        if (dut_state() !== 25'd0 || oReady !== 1'b1) begin
            n_err++; $display("FAIL arst_immediate got %h rdy %b exp 0 rdy 1", dut_state(), oReady);
        end
        // Release between edges; the next edge is the first one allowed to transfer.
        #2;
        iRst_n = 1'b1;
        model_clear();
        #1;
        drive(1'b1, 4'hB, 2'd2, 1'b0, 4'h0);
        exp_s = exp_q.pop_front();
        n_vec++;
        if (oZ2 !== 4'hB || dut_state() !== exp_s) begin
            n_err++; $display("FAIL arst_first_xfer got %h exp %h", dut_state(), exp_s);
        end
    endtask

    initial begin
        iRst_n = 1'b0;
        iValid = 1'b0; iD = 4'h0; iS0 = 1'b0; iS1 = 1'b0; iAuto = 1'b0; iAck = 4'h0;
        model_clear();
        #6;
        test_reset();
        test_manual_sweep();
        test_backpressure();
        test_round_robin();
        test_mode_switch();
        test_spurious_ack();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
